// File: rtl/p_line_fill_pkg.sv
// Shared definitions for the program-cache line-fill engine: state
// encodings, line geometry and beat counter width.
package p_line_fill_pkg;

  localparam int LINE_AW = 14;
  localparam int WORD_W  = 16;
  localparam int BEATS   = 4;
  localparam int BEAT_W  = 2;
  localparam int LINE_W  = BEATS * WORD_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/p_line_fill.sv
// Line-fill engine for the program cache. Turns one 64-bit line request
// into four sequential 16-bit external reads, assembles the line and
// returns it with a one-cycle ready pulse that doubles as the cache's
// tag/data write enable.
module p_line_fill
  import p_line_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_AW-1:0]    mem_address,
  input  logic                  mem_req,
  output logic [LINE_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [LINE_AW+1:0]    ram_addr,
  output logic                  ram_rd_req,
  input  logic                  ram_ack,
  input  logic [WORD_W-1:0]     ram_rdata,
  output logic                  fill_active
);

  fill_state_t          state_reg, state_next;
  logic [BEAT_W-1:0]    beat_reg, beat_next;
  logic [LINE_AW-1:0]   line_reg, line_next;
  logic                 mem_ready_reg, mem_ready_next;
  logic [BEATS-1:0]     word_en;

  // State, beat counter, latched line address and ready pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      line_reg      <= '0;
      mem_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      line_reg      <= line_next;
      mem_ready_reg <= mem_ready_next;
    end
  end

  // Next-state logic: latch the line in IDLE, walk the beats on each ack,
  // then spend exactly one cycle in DONE while the ready pulse is out.
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    line_next      = line_reg;
    mem_ready_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          line_next  = mem_address;
          beat_next  = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ram_ack) begin
          if (beat_reg == LAST_BEAT) begin
            state_next     = ST_DONE;
            mem_ready_next = 1'b1;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        // mem_req is deliberately ignored here; the IDLE cycle that follows
        // is what spaces back-to-back fills.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One capture register per word, enabled only for the beat being acked.
  // Acks outside ISSUE never reach these enables.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    assign word_en[gi] = (state_reg == ST_ISSUE) && ram_ack &&
                         (beat_reg == BEAT_W'(gi));

    // Word gi holds until the next fill acks this same beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_reg <= '0;
      end else if (word_en[gi]) begin
        word_reg <= ram_rdata;
      end
    end

    assign mem_data[gi*WORD_W +: WORD_W] = word_reg;
  end

  // Memory-side outputs decode purely from registered state, so an async
  // reset drops the read request immediately.
  assign ram_rd_req  = (state_reg == ST_ISSUE);
  assign ram_addr    = {line_reg, beat_reg};
  assign mem_ready   = mem_ready_reg;
  assign fill_active = (state_reg == ST_ISSUE) || (state_reg == ST_DONE);

endmodule

// File: tb/tb_p_line_fill.sv
// Directed bench for p_line_fill: reset behaviour, zero-wait and wait-state
// fills, address wrap, spurious acks, mid-fill input changes, mid-fill reset.
module tb_p_line_fill;

  logic        clk;
  logic        rst_n;
  logic [13:0] mem_address;
  logic        mem_req;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic [15:0] ram_addr;
  logic        ram_rd_req;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic        fill_active;

  int tests_run    = 0;
  int tests_failed = 0;

  p_line_fill dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_address (mem_address),
    .mem_req     (mem_req),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .ram_addr    (ram_addr),
    .ram_rd_req  (ram_rd_req),
    .ram_ack     (ram_ack),
    .ram_rdata   (ram_rdata),
    .fill_active (fill_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one full fill of line 'addr' returning 'line'. Each beat waits
  // 'wt' idle cycles before its ack. If 'disturb' is set, mem_address is
  // changed mid-fill (mem_req is always dropped once the fill starts).
  task automatic run_fill(input logic [13:0] addr, input logic [63:0] line,
                          input int wt, input bit disturb);
    int cyc;
    next_cycle();
    mem_address = addr;
    mem_req     = 1'b1;
    ram_ack     = 1'b0;
    cyc = 0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w <= wt; w++) begin
        next_cycle();
        cyc++;
        mem_req = 1'b0;
        if (disturb) mem_address = ~addr;
        ram_ack   = (w == wt);
        ram_rdata = (w == wt) ? line[16*b +: 16] : 16'hDEAD;
        @(negedge clk);
        check($sformatf("rd_req b%0d w%0d", b, w), 64'(ram_rd_req), 64'd1);
        check($sformatf("addr b%0d w%0d", b, w), 64'(ram_addr), 64'({addr, 2'(b)}));
        check($sformatf("no_ready b%0d w%0d", b, w), 64'(mem_ready), 64'd0);
      end
    end
    next_cycle();
    cyc++;
    ram_ack   = 1'b0;
    ram_rdata = 16'hBEEF;
    @(negedge clk);
    check("ready_pulse", 64'(mem_ready), 64'd1);
    check("line_data", mem_data, line);
    check("done_no_req", 64'(ram_rd_req), 64'd0);
    check("done_active", 64'(fill_active), 64'd1);
    check("fill_cycles", 64'(cyc), 64'(4 * (wt + 1) + 1));
    next_cycle();
    @(negedge clk);
    check("ready_gone", 64'(mem_ready), 64'd0);
    check("idle_inactive", 64'(fill_active), 64'd0);
    check("idle_no_req", 64'(ram_rd_req), 64'd0);
    check("data_held", mem_data, line);
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_req     = 1'b1;
    mem_address = 14'h0000;
    ram_ack     = 1'b0;
    ram_rdata   = 16'h0000;

    // Reset held with a pending request: everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_req", 64'(ram_rd_req), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_ready", 64'(mem_ready), 64'd0);
    check("rst_data", mem_data, 64'd0);
    check("rst_active", 64'(fill_active), 64'd0);

    // Release: the held request starts a fill at line 0 next cycle.
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_rst_rd_req", 64'(ram_rd_req), 64'd1);
    check("post_rst_addr", 64'(ram_addr), 64'h0000);

    // Abandon that fill by reset; request drops asynchronously.
    mem_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_drop", 64'(ram_rd_req), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Zero-wait fill.
    run_fill(14'h0123, 64'hA333_A222_A111_A000, 0, 1'b0);

    // Spurious ack in IDLE: no capture, no state change.
    next_cycle();
    ram_ack   = 1'b1;
    ram_rdata = 16'hFFFF;
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    check("spur_data", mem_data, 64'hA333_A222_A111_A000);
    check("spur_active", 64'(fill_active), 64'd0);
    check("spur_rd_req", 64'(ram_rd_req), 64'd0);
    check("spur_ready", 64'(mem_ready), 64'd0);

    // Wait states: 3 idle cycles before each ack.
    run_fill(14'h0456, 64'h1234_5678_9ABC_DEF0, 3, 1'b0);

    // Top line: word address must not carry past FFFF.
    run_fill(14'h3FFF, 64'hC003_C002_C001_C000, 1, 1'b0);

    // mem_address changes and mem_req drops mid-fill: original line completes.
    run_fill(14'h0A5A, 64'h0D0C_0B0A_0908_0706, 1, 1'b1);

    // Mid-fill reset after two beats acked.
    next_cycle();
    mem_address = 14'h0055;
    mem_req     = 1'b1;
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      mem_req   = 1'b0;
      ram_ack   = 1'b1;
      ram_rdata = 16'h7700 + 16'(b);
    end
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    check("mid_addr_beat2", 64'(ram_addr), 64'({14'h0055, 2'd2}));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rd_req", 64'(ram_rd_req), 64'd0);
    check("mid_rst_ready", 64'(mem_ready), 64'd0);
    check("mid_rst_data", mem_data, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("aborted_no_ready", 64'(mem_ready), 64'd0);

    // Next request restarts from beat 0.
    run_fill(14'h2AAA, 64'h4444_3333_2222_1111, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
